// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//
// Shares the single register-file write port between the in-order pipeline
// write-back path and a late-completion requester (for example multi-cycle
// I/O reads that return after their instruction has left MEM).
//
//   * Pipeline writes always win the slot.
//   * Late results go into a small FIFO and are written in free slots.
//   * A starvation counter raises stall_req so the pipeline inserts a bubble
//     when the FIFO head has waited MAX_WAIT cycles.
//   * query_hit lets ID detect a RAW hazard against buffered results.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   pipe_wb_enable/reg/data    pipeline write request (no backpressure)
//   late_valid/ready/reg/data  late-result handshake
//   stall_req                  registered bubble request
//   query_reg / query_hit      pending-destination lookup (combinational)
//   regif_wb_enable/reg/data   registered register-file write
//   df_wb_enable/reg/data      forwarding copies of regif_*
//
// Late handshake: a transfer happens on a rising edge where late_valid and
// late_ready are both 1. late_ready is simply "FIFO not full" and never
// depends on late_valid or on a same-cycle pop. A transfer to x0 is accepted
// but dropped.

module wb_port_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_wb_enable,
    input  logic [4:0]  pipe_wb_reg,
    input  logic [31:0] pipe_wb_data,
    input  logic        late_valid,
    output logic        late_ready,
    input  logic [4:0]  late_reg,
    input  logic [31:0] late_data,
    output logic        stall_req,
    input  logic [4:0]  query_reg,
    output logic        query_hit,
    output logic        regif_wb_enable,
    output logic [4:0]  regif_wb_reg,
    output logic [31:0] regif_wb_data,
    output logic        df_wb_enable,
    output logic [4:0]  df_wb_reg,
    output logic [31:0] df_wb_data
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [WW-1:0] MAX_WAIT_C = WW'(MAX_WAIT);

    // FIFO storage and bookkeeping
    logic [4:0]    fifo_reg_q  [DEPTH];
    logic [4:0]    fifo_reg_d  [DEPTH];
    logic [31:0]   fifo_data_q [DEPTH];
    logic [31:0]   fifo_data_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Starvation tracking
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic          stall_req_q, stall_req_d;

    // Registered write port
    logic          regif_wb_enable_q, regif_wb_enable_d;
    logic [4:0]    regif_wb_reg_q, regif_wb_reg_d;
    logic [31:0]   regif_wb_data_q, regif_wb_data_d;

    // Slot decisions
    logic full;
    logic empty;
    logic late_fire;
    logic push;
    logic pipe_owns;
    logic pop;

    always_comb begin
        full      = (count_q == DEPTH_C);
        empty     = (count_q == '0);
        late_fire = late_valid && !full;
        // x0 results are consumed by the handshake but never stored.
        push      = late_fire && (late_reg != 5'd0);
        // A pipeline write to x0 does not claim the slot, so the FIFO may use it.
        pipe_owns = pipe_wb_enable && (pipe_wb_reg != 5'd0);
        pop       = !pipe_owns && !empty;
    end

    // FIFO next state
    always_comb begin
        fifo_reg_d  = fifo_reg_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (push) begin
            fifo_reg_d[wr_ptr_q]  = late_reg;
            fifo_data_d[wr_ptr_q] = late_data;
            wr_ptr_d              = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Starvation counter and bubble request
    always_comb begin
        wait_cnt_d  = wait_cnt_q;
        stall_req_d = stall_req_q;
        if (empty || pop) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != MAX_WAIT_C) begin
            wait_cnt_d = wait_cnt_q + WW'(1);
        end
        // A pop resolves the starvation; otherwise raise once the limit is hit
        // and hold until the head finally drains.
        if (pop) begin
            stall_req_d = 1'b0;
        end else if (wait_cnt_d == MAX_WAIT_C) begin
            stall_req_d = 1'b1;
        end
    end

    // Write-port selection; reg/data hold when nobody writes.
    always_comb begin
        regif_wb_enable_d = pipe_owns || pop;
        regif_wb_reg_d    = regif_wb_reg_q;
        regif_wb_data_d   = regif_wb_data_q;
        if (pipe_owns) begin
            regif_wb_reg_d  = pipe_wb_reg;
            regif_wb_data_d = pipe_wb_data;
        end else if (pop) begin
            regif_wb_reg_d  = fifo_reg_q[rd_ptr_q];
            regif_wb_data_d = fifo_data_q[rd_ptr_q];
        end
    end

    // Pending-destination lookup. The head being popped is excluded because
    // it reaches ID through df_* next cycle; an entry being pushed is not yet
    // stored, so it is excluded naturally.
    always_comb begin
        query_hit = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((CW'(k) < count_q) && !((k == 0) && pop) &&
                (fifo_reg_q[rd_ptr_q + PW'(k)] == query_reg) &&
                (query_reg != 5'd0)) begin
                query_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_reg_q[i]  <= '0;
                fifo_data_q[i] <= '0;
            end
            wr_ptr_q          <= '0;
            rd_ptr_q          <= '0;
            count_q           <= '0;
            wait_cnt_q        <= '0;
            stall_req_q       <= 1'b0;
            regif_wb_enable_q <= 1'b0;
            regif_wb_reg_q    <= '0;
            regif_wb_data_q   <= '0;
        end else begin
            fifo_reg_q        <= fifo_reg_d;
            fifo_data_q       <= fifo_data_d;
            wr_ptr_q          <= wr_ptr_d;
            rd_ptr_q          <= rd_ptr_d;
            count_q           <= count_d;
            wait_cnt_q        <= wait_cnt_d;
            stall_req_q       <= stall_req_d;
            regif_wb_enable_q <= regif_wb_enable_d;
            regif_wb_reg_q    <= regif_wb_reg_d;
            regif_wb_data_q   <= regif_wb_data_d;
        end
    end

    assign late_ready      = !full;
    assign stall_req       = stall_req_q;
    assign regif_wb_enable = regif_wb_enable_q;
    assign regif_wb_reg    = regif_wb_reg_q;
    assign regif_wb_data   = regif_wb_data_q;
    assign df_wb_enable    = regif_wb_enable_q;
    assign df_wb_reg       = regif_wb_reg_q;
    assign df_wb_data      = regif_wb_data_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed testbench for wb_port_arbiter (DEPTH = 2, MAX_WAIT = 4).
// Inputs are driven 1 time unit after each rising edge; registered outputs
// are sampled there, combinational outputs 1 more unit later.

module tb_wb_port_arbiter;

    logic        clk;
    logic        reset;
    logic        pipe_wb_enable;
    logic [4:0]  pipe_wb_reg;
    logic [31:0] pipe_wb_data;
    logic        late_valid;
    logic        late_ready;
    logic [4:0]  late_reg;
    logic [31:0] late_data;
    logic        stall_req;
    logic [4:0]  query_reg;
    logic        query_hit;
    logic        regif_wb_enable;
    logic [4:0]  regif_wb_reg;
    logic [31:0] regif_wb_data;
    logic        df_wb_enable;
    logic [4:0]  df_wb_reg;
    logic [31:0] df_wb_data;

    int n_checks = 0;
    int n_pass   = 0;

    wb_port_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .pipe_wb_enable  (pipe_wb_enable),
        .pipe_wb_reg     (pipe_wb_reg),
        .pipe_wb_data    (pipe_wb_data),
        .late_valid      (late_valid),
        .late_ready      (late_ready),
        .late_reg        (late_reg),
        .late_data       (late_data),
        .stall_req       (stall_req),
        .query_reg       (query_reg),
        .query_hit       (query_hit),
        .regif_wb_enable (regif_wb_enable),
        .regif_wb_reg    (regif_wb_reg),
        .regif_wb_data   (regif_wb_data),
        .df_wb_enable    (df_wb_enable),
        .df_wb_reg       (df_wb_reg),
        .df_wb_data      (df_wb_data)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Driver tasks
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle;
        pipe_wb_enable = 1'b0;
        pipe_wb_reg    = 5'd0;
        pipe_wb_data   = 32'd0;
        late_valid     = 1'b0;
        late_reg       = 5'd0;
        late_data      = 32'd0;
        query_reg      = 5'd0;
    endtask

    task automatic drive_pipe(input logic en, input logic [4:0] r, input logic [31:0] d);
        pipe_wb_enable = en;
        pipe_wb_reg    = r;
        pipe_wb_data   = d;
    endtask

    task automatic drive_late(input logic v, input logic [4:0] r, input logic [31:0] d);
        late_valid = v;
        late_reg   = r;
        late_data  = d;
    endtask

    // Scenarios
    task automatic test_reset;
        reset = 1'b1;
        set_idle();
        repeat (3) tick();
        reset = 1'b0;
        query_reg = 5'd7;
        #1;
        n_checks++; if (regif_wb_enable !== 1'b0) $display("FAIL rst_en got %0b exp 0", regif_wb_enable); else n_pass++;
        n_checks++; if (regif_wb_reg !== 5'd0) $display("FAIL rst_reg got %0d exp 0", regif_wb_reg); else n_pass++;
        n_checks++; if (regif_wb_data !== 32'd0) $display("FAIL rst_data got %h exp 0", regif_wb_data); else n_pass++;
        n_checks++; if (stall_req !== 1'b0) $display("FAIL rst_stall got %0b exp 0", stall_req); else n_pass++;
        n_checks++; if (late_ready !== 1'b1) $display("FAIL rst_ready got %0b exp 1", late_ready); else n_pass++;
        n_checks++; if (query_hit !== 1'b0) $display("FAIL rst_hit got %0b exp 0", query_hit); else n_pass++;
        n_checks++; if (df_wb_enable !== 1'b0) $display("FAIL rst_df_en got %0b exp 0", df_wb_enable); else n_pass++;
        set_idle();
    endtask

    task automatic test_pipeline;
        drive_pipe(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        n_checks++; if (regif_wb_enable !== 1'b1) $display("FAIL pipe_en got %0b exp 1", regif_wb_enable); else n_pass++;
        n_checks++; if (regif_wb_reg !== 5'd5) $display("FAIL pipe_reg got %0d exp 5", regif_wb_reg); else n_pass++;
        n_checks++; if (regif_wb_data !== 32'hDEADBEEF) $display("FAIL pipe_data got %h exp deadbeef", regif_wb_data); else n_pass++;
        n_checks++; if (df_wb_data !== 32'hDEADBEEF) $display("FAIL pipe_df_data got %h exp deadbeef", df_wb_data); else n_pass++;
        drive_pipe(1'b1, 5'd0, 32'h1234);
        tick();
        n_checks++; if (regif_wb_enable !== 1'b0) $display("FAIL pipe_x0_en got %0b exp 0", regif_wb_enable); else n_pass++;
        n_checks++; if (regif_wb_reg !== 5'd5) $display("FAIL pipe_x0_hold_reg got %0d exp 5", regif_wb_reg); else n_pass++;
        n_checks++; if (regif_wb_data !== 32'hDEADBEEF) $display("FAIL pipe_x0_hold_data got %h exp deadbeef", regif_wb_data); else n_pass++;
        drive_pipe(1'b1, 5'd3, 32'h11112222);
        tick();
        n_checks++; if (regif_wb_reg !== 5'd3 || regif_wb_data !== 32'h11112222) $display("FAIL pipe_x3 got %0d/%h exp 3/11112222", regif_wb_reg, regif_wb_data); else n_pass++;
        set_idle();
        tick();
        n_checks++; if (regif_wb_enable !== 1'b0 || regif_wb_reg !== 5'd3) $display("FAIL pipe_idle got %0b/%0d exp 0/3", regif_wb_enable, regif_wb_reg); else n_pass++;
    endtask

    task automatic test_late_idle;
        drive_late(1'b1, 5'd7, 32'hA5A5A5A5);
        query_reg = 5'd7;
        #1;
        n_checks++; if (late_ready !== 1'b1) $display("FAIL late_ready got %0b exp 1", late_ready); else n_pass++;
        n_checks++; if (query_hit !== 1'b0) $display("FAIL late_push_hit got %0b exp 0", query_hit); else n_pass++;
        tick();
        drive_late(1'b0, 5'd0, 32'd0);
        #1;
        // Head is present but popped this cycle, so no hit.
        n_checks++; if (query_hit !== 1'b0) $display("FAIL late_pop_hit got %0b exp 0", query_hit); else n_pass++;
        n_checks++; if (regif_wb_enable !== 1'b0) $display("FAIL late_early_en got %0b exp 0", regif_wb_enable); else n_pass++;
        tick();
        n_checks++; if (regif_wb_enable !== 1'b1 || regif_wb_reg !== 5'd7 || regif_wb_data !== 32'hA5A5A5A5)
            $display("FAIL late_write got %0b/%0d/%h exp 1/7/a5a5a5a5", regif_wb_enable, regif_wb_reg, regif_wb_data); else n_pass++;
        n_checks++; if (query_hit !== 1'b0) $display("FAIL late_after_hit got %0b exp 0", query_hit); else n_pass++;
        set_idle();
        tick();
    endtask

    task automatic test_query;
        drive_pipe(1'b1, 5'd1, 32'h1);
        drive_late(1'b1, 5'd12, 32'hC);
        tick();
        drive_late(1'b0, 5'd0, 32'd0);
        drive_pipe(1'b1, 5'd2, 32'h2);
        query_reg = 5'd12;
        #1;
        n_checks++; if (query_hit !== 1'b1) $display("FAIL q_hit12 got %0b exp 1", query_hit); else n_pass++;
        query_reg = 5'd13;
        #1;
        n_checks++; if (query_hit !== 1'b0) $display("FAIL q_miss13 got %0b exp 0", query_hit); else n_pass++;
        query_reg = 5'd0;
        #1;
        n_checks++; if (query_hit !== 1'b0) $display("FAIL q_x0 got %0b exp 0", query_hit); else n_pass++;
        tick();
        drive_pipe(1'b0, 5'd0, 32'd0);
        query_reg = 5'd12;
        #1;
        n_checks++; if (query_hit !== 1'b0) $display("FAIL q_popping got %0b exp 0", query_hit); else n_pass++;
        tick();
        n_checks++; if (regif_wb_enable !== 1'b1 || regif_wb_reg !== 5'd12 || regif_wb_data !== 32'hC)
            $display("FAIL q_write got %0b/%0d/%h exp 1/12/c", regif_wb_enable, regif_wb_reg, regif_wb_data); else n_pass++;
        set_idle();
        tick();
    endtask

    task automatic test_conflict;
        drive_pipe(1'b1, 5'd1, 32'h101);
        drive_late(1'b1, 5'd9, 32'h99);
        tick();
        drive_late(1'b0, 5'd0, 32'd0);
        for (int i = 2; i <= 6; i++) begin
            n_checks++; if (regif_wb_reg !== 5'(i - 1) || regif_wb_data !== 32'h100 + 32'(i - 1))
                $display("FAIL cf_pipe%0d got %0d/%h", i - 1, regif_wb_reg, regif_wb_data); else n_pass++;
            n_checks++; if (stall_req !== (i == 6))
                $display("FAIL cf_stall%0d got %0b exp %0b", i - 1, stall_req, (i == 6)); else n_pass++;
            drive_pipe(1'b1, 5'(i), 32'h100 + 32'(i));
            tick();
        end
        // Pipeline keeps priority while stall_req is high.
        n_checks++; if (regif_wb_enable !== 1'b1 || regif_wb_reg !== 5'd6) $display("FAIL cf_prio got %0b/%0d exp 1/6", regif_wb_enable, regif_wb_reg); else n_pass++;
        n_checks++; if (stall_req !== 1'b1) $display("FAIL cf_stall_hold got %0b exp 1", stall_req); else n_pass++;
        drive_pipe(1'b0, 5'd0, 32'd0);
        tick();
        n_checks++; if (regif_wb_enable !== 1'b1 || regif_wb_reg !== 5'd9 || regif_wb_data !== 32'h99)
            $display("FAIL cf_late got %0b/%0d/%h exp 1/9/99", regif_wb_enable, regif_wb_reg, regif_wb_data); else n_pass++;
        n_checks++; if (stall_req !== 1'b0) $display("FAIL cf_stall_clr got %0b exp 0", stall_req); else n_pass++;
        tick();
        n_checks++; if (regif_wb_enable !== 1'b0) $display("FAIL cf_idle got %0b exp 0", regif_wb_enable); else n_pass++;
    endtask

    task automatic test_fifo_full;
        drive_pipe(1'b1, 5'd1, 32'h1);
        drive_late(1'b1, 5'd3, 32'h33);
        tick();
        drive_late(1'b1, 5'd4, 32'h44);
        #1;
        n_checks++; if (late_ready !== 1'b1) $display("FAIL ff_ready1 got %0b exp 1", late_ready); else n_pass++;
        tick();
        drive_late(1'b1, 5'd5, 32'h55);
        query_reg = 5'd4;
        #1;
        n_checks++; if (late_ready !== 1'b0) $display("FAIL ff_full got %0b exp 0", late_ready); else n_pass++;
        n_checks++; if (query_hit !== 1'b1) $display("FAIL ff_hit4 got %0b exp 1", query_hit); else n_pass++;
        query_reg = 5'd3;
        #1;
        n_checks++; if (query_hit !== 1'b1) $display("FAIL ff_hit3 got %0b exp 1", query_hit); else n_pass++;
        tick();
        drive_pipe(1'b0, 5'd0, 32'd0);
        query_reg = 5'd0;
        #1;
        n_checks++; if (late_ready !== 1'b0) $display("FAIL ff_pop_ready got %0b exp 0", late_ready); else n_pass++;
        tick();
        n_checks++; if (regif_wb_enable !== 1'b1 || regif_wb_reg !== 5'd3 || regif_wb_data !== 32'h33)
            $display("FAIL ff_first got %0b/%0d/%h exp 1/3/33", regif_wb_enable, regif_wb_reg, regif_wb_data); else n_pass++;
        n_checks++; if (late_ready !== 1'b1) $display("FAIL ff_ready_rise got %0b exp 1", late_ready); else n_pass++;
        tick();
        drive_late(1'b0, 5'd0, 32'd0);
        n_checks++; if (regif_wb_reg !== 5'd4 || regif_wb_data !== 32'h44) $display("FAIL ff_second got %0d/%h exp 4/44", regif_wb_reg, regif_wb_data); else n_pass++;
        tick();
        n_checks++; if (regif_wb_enable !== 1'b1 || regif_wb_reg !== 5'd5 || regif_wb_data !== 32'h55)
            $display("FAIL ff_third got %0b/%0d/%h exp 1/5/55", regif_wb_enable, regif_wb_reg, regif_wb_data); else n_pass++;
        tick();
        n_checks++; if (regif_wb_enable !== 1'b0) $display("FAIL ff_drained got %0b exp 0", regif_wb_enable); else n_pass++;
        set_idle();
    endtask

    task automatic test_late_x0;
        drive_late(1'b1, 5'd0, 32'hFFFF);
        #1;
        n_checks++; if (late_ready !== 1'b1) $display("FAIL x0_ready got %0b exp 1", late_ready); else n_pass++;
        tick();
        tick();
        drive_late(1'b0, 5'd0, 32'd0);
        #1;
        // Two x0 offers were taken; a counted FIFO would now be full.
        n_checks++; if (late_ready !== 1'b1) $display("FAIL x0_not_full got %0b exp 1", late_ready); else n_pass++;
        n_checks++; if (regif_wb_enable !== 1'b0) $display("FAIL x0_no_write1 got %0b exp 0", regif_wb_enable); else n_pass++;
        tick();
        n_checks++; if (regif_wb_enable !== 1'b0) $display("FAIL x0_no_write2 got %0b exp 0", regif_wb_enable); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid;
        drive_pipe(1'b1, 5'd1, 32'h1);
        drive_late(1'b1, 5'd10, 32'hAA);
        tick();
        drive_late(1'b1, 5'd11, 32'hBB);
        tick();
        drive_late(1'b0, 5'd0, 32'd0);
        repeat (3) tick();
        n_checks++; if (stall_req !== 1'b1) $display("FAIL rm_stall got %0b exp 1", stall_req); else n_pass++;
        drive_pipe(1'b0, 5'd0, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        query_reg = 5'd10;
        #1;
        n_checks++; if (regif_wb_enable !== 1'b0 || regif_wb_reg !== 5'd0 || regif_wb_data !== 32'd0)
            $display("FAIL rm_regif got %0b/%0d/%h exp 0/0/0", regif_wb_enable, regif_wb_reg, regif_wb_data); else n_pass++;
        n_checks++; if (stall_req !== 1'b0) $display("FAIL rm_stall_clr got %0b exp 0", stall_req); else n_pass++;
        n_checks++; if (late_ready !== 1'b1) $display("FAIL rm_ready got %0b exp 1", late_ready); else n_pass++;
        n_checks++; if (query_hit !== 1'b0) $display("FAIL rm_hit got %0b exp 0", query_hit); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (regif_wb_enable !== 1'b0) $display("FAIL rm_no_write%0d got %0b exp 0", i, regif_wb_enable); else n_pass++;
        end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_pipeline();
        test_late_idle();
        test_query();
        test_conflict();
        test_fifo_full();
        test_late_x0();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
